stb_seq_ctrl: RTL

STB_SEQ_CTRL -- requirements
Module: stb_seq_ctrl

---
 rtl/measure_unit_pkg.sv | 36 +++
 rtl/seq_down_cnt.sv | 35 +++
 rtl/stb_seq_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/measure_unit_pkg.sv
// Shared definitions for the strobe-sequencing controller.
//
// Contents:
//   - Default widths for the period word, burst counter and timeout counter.
//   - One-hot state encoding of the burst sequencer FSM.
//   - Small helpers that classify FSM states.
package measure_unit_pkg;

    localparam int unsigned T_CNT_WIDTH_DEF = 32;
    localparam int unsigned N_WIDTH_DEF     = 16;
    localparam int unsigned TO_WIDTH_DEF    = 24;
    localparam int unsigned GAP_WIDTH       = 16;

    typedef enum logic [7:0] {
        StIdle     = 8'b0000_0001,
        StWaitRdy  = 8'b0000_0010,
        StReq      = 8'b0000_0100,
        StWaitAck  = 8'b0000_1000,
        StWaitDone = 8'b0001_0000,
        StGap      = 8'b0010_0000,
        StDone     = 8'b0100_0000,
        StError    = 8'b1000_0000
    } seq_state_e;

    // States in which a generator error aborts the burst into ERROR.
    function automatic logic err_sensitive(input seq_state_e st);
        return (st == StWaitRdy) || (st == StReq) || (st == StWaitAck) ||
               (st == StWaitDone) || (st == StGap);
    endfunction

    // States guarded by the per-phase timeout.
    function automatic logic is_wait_state(input seq_state_e st);
        return (st == StWaitRdy) || (st == StWaitAck) || (st == StWaitDone);
    endfunction

endpackage

// File: rtl/seq_down_cnt.sv
// Loadable down-counter with a zero flag.
//
// Ports:
//   clk_i        clock, all logic on posedge
//   rst_i        synchronous active-high reset, clears the count
//   load_i       load load_val_i (wins over en_i)
//   en_i         decrement by one while the count is non-zero
//   load_val_i   value to load
//   zero_o       count is zero
module seq_down_cnt #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/stb_seq_ctrl.sv
// Burst sequencer for an external strobe generator.
//
// On start_i in IDLE it latches num_stb_i / gap_i / timeout_i and issues num_stb_i
// strobe requests, waiting for the generator to be ready, to accept each request
// and to report completion. Completed strobes are counted and the extremes of the
// reported period are tracked. Wait phases are guarded by a reloadable timeout.
//
// Ports:
//   clk_i, rst_i          clock and synchronous active-high reset
//   start_i, abort_i      begin burst (IDLE only) / cancel burst
//   num_stb_i, gap_i      strobes per burst, idle cycles between strobes
//   timeout_i             max cycles per wait phase, 0 disables
//   gen_rdy_i, gen_err_i  generator locked / generator error
//   gen_valid_i           generator idle / strobe-complete flag
//   gen_period_i          measured period reported with each completion
//   stb_req_o             one-cycle strobe request (registered)
//   busy_o, done_o        not idle / burst finished cleanly (pulse)
//   fail_o, timeout_o     sticky failure flag and its timeout cause
//   stb_cnt_o             strobes completed in current/last burst
//   period_min_o/max_o    period extremes over completed strobes
module stb_seq_ctrl
    import measure_unit_pkg::*;
#(
    parameter int unsigned T_CNT_WIDTH = T_CNT_WIDTH_DEF,
    parameter int unsigned N_WIDTH     = N_WIDTH_DEF,
    parameter int unsigned TO_WIDTH    = TO_WIDTH_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [N_WIDTH-1:0]     num_stb_i,
    input  logic [GAP_WIDTH-1:0]   gap_i,
    input  logic [TO_WIDTH-1:0]    timeout_i,
    input  logic                   gen_rdy_i,
    input  logic                   gen_err_i,
    input  logic                   gen_valid_i,
    input  logic [T_CNT_WIDTH-1:0] gen_period_i,
    output logic                   stb_req_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   fail_o,
    output logic                   timeout_o,
    output logic [N_WIDTH-1:0]     stb_cnt_o,
    output logic [T_CNT_WIDTH-1:0] period_min_o,
    output logic [T_CNT_WIDTH-1:0] period_max_o
);

    seq_state_e state_q, state_d;

    logic [N_WIDTH-1:0]     num_q;
    logic [GAP_WIDTH-1:0]   gap_q;
    logic [TO_WIDTH-1:0]    to_q;
    logic [N_WIDTH-1:0]     stb_cnt_q;
    logic [N_WIDTH-1:0]     stb_cnt_inc;
    logic [T_CNT_WIDTH-1:0] min_q, max_q;
    logic                   fail_q, tmo_q, stb_req_q, done_q;

    logic                   accept_start;
    logic                   strobe_done;
    logic                   to_fire;
    logic                   to_expired;

    logic                   to_load, to_en, to_zero;
    logic [TO_WIDTH-1:0]    to_load_val;
    logic                   gap_load, gap_en, gap_zero;
    logic [GAP_WIDTH-1:0]   gap_load_val;

    assign stb_cnt_inc = stb_cnt_q + N_WIDTH'(1);

    // Both counters are loaded with (length - 1) so the zero flag marks the last
    // cycle of the phase: a wait phase of timeout T expires on its T-th cycle and
    // GAP lasts exactly gap cycles.
    assign to_load     = is_wait_state(state_d) && (state_d != state_q);
    assign to_en       = is_wait_state(state_q);
    // Entry to WAIT_RDY happens from IDLE, before timeout_i has been latched.
    assign to_load_val = (state_q == StIdle) ? (timeout_i - TO_WIDTH'(1))
                                             : (to_q - TO_WIDTH'(1));
    assign to_expired  = (to_q != '0) && to_zero;

    assign gap_load     = (state_d == StGap) && (state_q != StGap);
    assign gap_en       = (state_q == StGap);
    assign gap_load_val = gap_q - GAP_WIDTH'(1);

    seq_down_cnt #(
        .WIDTH (TO_WIDTH)
    ) u_to_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (to_load),
        .en_i       (to_en),
        .load_val_i (to_load_val),
        .zero_o     (to_zero)
    );

    seq_down_cnt #(
        .WIDTH (GAP_WIDTH)
    ) u_gap_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (gap_load),
        .en_i       (gap_en),
        .load_val_i (gap_load_val),
        .zero_o     (gap_zero)
    );

    always_comb begin
        state_d      = state_q;
        accept_start = 1'b0;
        strobe_done  = 1'b0;
        to_fire      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    accept_start = 1'b1;
                    state_d      = (num_stb_i == '0) ? StDone : StWaitRdy;
                end
            end
            StWaitRdy: begin
                if (gen_rdy_i && gen_valid_i) begin
                    state_d = StReq;
                end else if (to_expired) begin
                    to_fire = 1'b1;
                end
            end
            StReq: begin
                state_d = StWaitAck;
            end
            StWaitAck: begin
                if (!gen_valid_i) begin
                    state_d = StWaitDone;
                end else if (to_expired) begin
                    to_fire = 1'b1;
                end
            end
            StWaitDone: begin
                if (gen_valid_i) begin
                    strobe_done = 1'b1;
                    if (stb_cnt_inc == num_q) begin
                        state_d = StDone;
                    end else if (gap_q == '0) begin
                        state_d = StReq;
                    end else begin
                        state_d = StGap;
                    end
                end else if (to_expired) begin
                    to_fire = 1'b1;
                end
            end
            StGap: begin
                if (gap_zero) begin
                    state_d = StReq;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            StError: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (to_fire) begin
            state_d = StError;
        end

        // Generator error outranks a timeout or a normal transition.
        if (err_sensitive(state_q) && gen_err_i) begin
            state_d     = StError;
            strobe_done = 1'b0;
            to_fire     = 1'b0;
        end

        // Abort outranks everything except reset; results are left untouched.
        if (abort_i && (state_q != StIdle)) begin
            state_d     = StIdle;
            strobe_done = 1'b0;
            to_fire     = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            num_q     <= '0;
            gap_q     <= '0;
            to_q      <= '0;
            stb_cnt_q <= '0;
            min_q     <= '1;
            max_q     <= '0;
            fail_q    <= 1'b0;
            tmo_q     <= 1'b0;
            stb_req_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            stb_req_q <= (state_d == StReq);
            // done_o is registered off the DONE state, so it lands the cycle
            // after DONE; an abort during DONE suppresses it.
            done_q    <= (state_q == StDone) && !abort_i;

            if (accept_start) begin
                num_q     <= num_stb_i;
                gap_q     <= gap_i;
                to_q      <= timeout_i;
                stb_cnt_q <= '0;
                min_q     <= '1;
                max_q     <= '0;
                fail_q    <= 1'b0;
                tmo_q     <= 1'b0;
            end

            if (strobe_done) begin
                stb_cnt_q <= stb_cnt_inc;
                if (gen_period_i < min_q) begin
                    min_q <= gen_period_i;
                end
                if (gen_period_i > max_q) begin
                    max_q <= gen_period_i;
                end
            end

            if (to_fire) begin
                tmo_q <= 1'b1;
            end

            if ((state_d == StError) && (state_q != StError)) begin
                fail_q <= 1'b1;
            end
        end
    end

    assign stb_req_o    = stb_req_q;
    assign busy_o       = (state_q != StIdle);
    assign done_o       = done_q;
    assign fail_o       = fail_q;
    assign timeout_o    = tmo_q;
    assign stb_cnt_o    = stb_cnt_q;
    assign period_min_o = min_q;
    assign period_max_o = max_q;

endmodule
